// File: rtl/expr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : expr_sequencer
// Description : Left-to-right expression scheduler for a shared sign-magnitude
//               ALU. Accepts {operand, operator} terms over valid/ready, drives
//               the ALU operands, folds each ALU result into an accumulator and
//               holds the final value with neg/zero/dbz/trunc flags until ack.
// Ports       : clk, rst_n             - clock, async active-low reset
//               in_valid_i/in_ready_o  - term handshake
//               in_operand_i, in_op_i, in_last_i - term payload
//               alu_a_o, alu_b_o, alu_op_o       - to ALU
//               alu_result_i, alu_dbz_i          - from ALU (combinational)
//               res_valid_o/res_ack_i  - result handshake
//               result_o, flag_*_o     - final accumulator and flags
//               busy_o, term_count_o   - status
//               step_i                 - only with EXPR_SEQ_STEP_EN defined
// Options     : EXPR_SEQ_STEP_EN - EXEC waits for step_i=1 before completing
// Revision    : 1.0 - initial release
// ============================================================================
module expr_sequencer #(
  parameter int WIDTH     = 9,
  parameter int MAX_TERMS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_operand_i,
  input  logic [1:0]       in_op_i,
  input  logic             in_last_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [1:0]       alu_op_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_dbz_i,
  output logic             res_valid_o,
  input  logic             res_ack_i,
  output logic [WIDTH-1:0] result_o,
  output logic             flag_neg_o,
  output logic             flag_zero_o,
  output logic             flag_dbz_o,
  output logic             flag_trunc_o,
  output logic             busy_o,
`ifdef EXPR_SEQ_STEP_EN
  input  logic             step_i,
`endif
  output logic [2:0]       term_count_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] c_MAX_TERMS = 3'(MAX_TERMS);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic             last_q, last_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;
  logic             trunc_q, trunc_d;

  logic             w_xfer;
  logic             w_exec_go;

  // Magnitude-based decodes: negative zero reads as zero, never as negative.
  function automatic logic is_neg(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] && (|v[WIDTH-2:0]);
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return ~(|v[WIDTH-2:0]);
  endfunction

  assign in_ready_o = (state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign w_xfer     = in_valid_i && in_ready_o;

`ifdef EXPR_SEQ_STEP_EN
  assign w_exec_go  = step_i;
`else
  assign w_exec_go  = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    trunc_d  = trunc_q;

    case (state_q)
      S_IDLE: begin
        if (w_xfer) begin
          acc_d   = in_operand_i;
          cnt_d   = 3'd1;
          neg_d   = is_neg(in_operand_i);
          zero_d  = is_zero(in_operand_i);
          dbz_d   = 1'b0;
          trunc_d = 1'b0;
          state_d = in_last_i ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_xfer) begin
          alu_b_d  = in_operand_i;
          alu_op_d = in_op_i;
          last_d   = in_last_i;
          cnt_d    = cnt_q + 3'd1;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_exec_go) begin
          if (alu_dbz_i) begin
            // Keep the pre-divide accumulator; remaining beats must be drained.
            dbz_d   = 1'b1;
            state_d = last_q ? S_DONE : S_DRAIN;
          end else begin
            acc_d  = alu_result_i;
            neg_d  = is_neg(alu_result_i);
            zero_d = is_zero(alu_result_i);
            if (last_q) begin
              state_d = S_DONE;
            end else if (cnt_q == c_MAX_TERMS) begin
              trunc_d = 1'b1;
              state_d = S_DRAIN;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
      end
      S_DRAIN: begin
        if (w_xfer && in_last_i) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ack_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      alu_b_q  <= '0;
      alu_op_q <= 2'd0;
      last_q   <= 1'b0;
      cnt_q    <= 3'd0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      trunc_q  <= trunc_d;
    end
  end

  assign alu_a_o      = acc_q;
  assign alu_b_o      = alu_b_q;
  assign alu_op_o     = alu_op_q;
  assign res_valid_o  = (state_q == S_DONE);
  assign result_o     = acc_q;
  assign flag_neg_o   = neg_q;
  assign flag_zero_o  = zero_q;
  assign flag_dbz_o   = dbz_q;
  assign flag_trunc_o = trunc_q;
  assign busy_o       = (state_q != S_IDLE);
  assign term_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_expr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_expr_sequencer
// Description : Self-checking bench for expr_sequencer. Provides a
//               sign-magnitude ALU, an expression-level reference model and a
//               per-cycle compare process while a result is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_sequencer;
  localparam int W  = 9;
  localparam int MT = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_operand = '0;
  logic [1:0]   in_op = 2'd0;
  logic         in_last = 1'b0;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic [1:0]   alu_op;
  logic         alu_dbz;
  logic         res_valid;
  logic         res_ack = 1'b0;
  logic [W-1:0] result;
  logic         flag_neg, flag_zero, flag_dbz, flag_trunc, busy;
  logic [2:0]   term_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [W-1:0] q_opnd[$];
  logic [1:0]   q_op[$];

  bit           armed = 1'b0;
  logic [W-1:0] exp_res;
  logic         exp_neg, exp_zero, exp_dbz, exp_trunc;
  logic [2:0]   exp_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  expr_sequencer #(.WIDTH(W), .MAX_TERMS(MT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_operand_i (in_operand),
    .in_op_i      (in_op),
    .in_last_i    (in_last),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_op_o     (alu_op),
    .alu_result_i (alu_result),
    .alu_dbz_i    (alu_dbz),
    .res_valid_o  (res_valid),
    .res_ack_i    (res_ack),
    .result_o     (result),
    .flag_neg_o   (flag_neg),
    .flag_zero_o  (flag_zero),
    .flag_dbz_o   (flag_dbz),
    .flag_trunc_o (flag_trunc),
    .busy_o       (busy),
`ifdef EXPR_SEQ_STEP_EN
    .step_i       (1'b1),
`endif
    .term_count_o (term_count)
  );

  // ---------------- sign-magnitude ALU (environment) ----------------
  function automatic int sm2int(input logic [W-1:0] v);
    int m;
    m = int'({24'd0, v[7:0]});
    return v[8] ? -m : m;
  endfunction

  function automatic logic [W-1:0] int2sm(input int r);
    int m;
    logic [7:0] mg;
    m  = (r < 0) ? -r : r;
    mg = m[7:0];
    return {(r < 0), mg};
  endfunction

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    int sa, sb, r;
    sa = sm2int(a);
    sb = sm2int(b);
    case (op)
      2'd0:    r = sa + sb;
      2'd1:    r = sa - sb;
      2'd2:    r = sa * sb;
      default: r = (sb == 0) ? 0 : sa / sb;
    endcase
    return int2sm(r);
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_op);
  assign alu_dbz    = (alu_op == 2'd3) && (alu_b[7:0] == 8'd0);

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  // Expression-level reference: evaluate the term list left to right,
  // stopping at the first divide by zero, the last term, or the term limit.
  task automatic model_expr();
    logic [W-1:0] acc;
    int n, last_idx;
    acc = q_opnd[0];
    n = 1;
    exp_dbz = 1'b0;
    exp_trunc = 1'b0;
    last_idx = q_opnd.size() - 1;
    for (int i = 1; i <= last_idx; i++) begin
      n++;
      if (q_op[i] == 2'd3 && q_opnd[i][7:0] == 8'd0) begin
        exp_dbz = 1'b1;
        break;
      end
      acc = alu_f(acc, q_opnd[i], q_op[i]);
      if (i == last_idx) break;
      if (n == MT) begin
        exp_trunc = 1'b1;
        break;
      end
    end
    exp_res  = acc;
    exp_zero = (acc[7:0] == 8'd0);
    exp_neg  = acc[8] && !exp_zero;
    exp_cnt  = 3'(n);
  endtask

  // Compare process: every cycle a result is presented it must match the model,
  // and the sequencer must refuse input.
  always @(negedge clk) begin
    if (rst_n && armed && res_valid) begin
      chk("result",     32'(result),     32'(exp_res));
      chk("flag_neg",   32'(flag_neg),   32'(exp_neg));
      chk("flag_zero",  32'(flag_zero),  32'(exp_zero));
      chk("flag_dbz",   32'(flag_dbz),   32'(exp_dbz));
      chk("flag_trunc", 32'(flag_trunc), 32'(exp_trunc));
      chk("term_count", 32'(term_count), 32'(exp_cnt));
      chk("ready_done", 32'(in_ready),   32'd0);
      chk("busy_done",  32'(busy),       32'd1);
    end
    if (rst_n && !busy) chk("ready_idle", 32'(in_ready), 32'd1);
  end

  task automatic send(input logic [W-1:0] o, input logic [1:0] p, input logic l);
    int k;
    k = 0;
    @(negedge clk);
    in_valid = 1'b1; in_operand = o; in_op = p; in_last = l;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic term(input logic [W-1:0] o, input logic [1:0] p);
    q_opnd.push_back(o);
    q_op.push_back(p);
  endtask

  // Runs the queued expression. lit_* are hand-computed literals (lit_lat=0
  // skips the latency check). poke drives a beat during DONE and the ack cycle.
  task automatic run_expr(input string nm, input logic [W-1:0] lit_res,
                          input logic [3:0] lit_flags, input int lit_lat,
                          input int hold, input bit poke);
    int c0, k, last_idx;
    model_expr();
    armed = 1'b1;
    last_idx = q_opnd.size() - 1;
    c0 = 0;
    for (int i = 0; i <= last_idx; i++) begin
      send(q_opnd[i], q_op[i], (i == last_idx));
      if (i == 0) c0 = cyc;
    end
    k = 0;
    while (!res_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) begin
      chk({nm, "_res_timeout"}, 32'd0, 32'd1);
    end else begin
      if (lit_lat != 0) chk({nm, "_latency"}, 32'(cyc - c0 + 1), 32'(lit_lat));
      chk({nm, "_lit_result"}, 32'(result), 32'(lit_res));
      chk({nm, "_lit_flags"}, 32'({flag_neg, flag_zero, flag_dbz, flag_trunc}), 32'(lit_flags));
    end
    if (poke) begin
      @(negedge clk);
      in_valid = 1'b1; in_operand = 9'h07F; in_op = 2'd0; in_last = 1'b1;
    end
    repeat (hold) @(negedge clk);
    if (poke) chk({nm, "_result_held"}, 32'(result), 32'(lit_res));
    res_ack = 1'b1;
    @(posedge clk);
    #1;
    res_ack = 1'b0;
    armed = 1'b0;
    chk({nm, "_idle_after_ack"}, 32'(busy), 32'd0);
    chk({nm, "_cnt_after_ack"}, 32'(term_count), 32'(exp_cnt));
    in_valid = 1'b0;
    in_last = 1'b0;
    q_opnd.delete();
    q_op.delete();
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({nm, "_busy"},      32'(busy),      32'd0);
    chk({nm, "_in_ready"},  32'(in_ready),  32'd1);
    chk({nm, "_result"},    32'(result),    32'd0);
    chk({nm, "_alu_ab_op"}, 32'({alu_a, alu_b, alu_op}), 32'd0);
    chk({nm, "_flags"},     32'({flag_neg, flag_zero, flag_dbz, flag_trunc}), 32'd0);
    chk({nm, "_count"},     32'(term_count), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: (2 + 3) * 1 = 5, five clocks from first beat to result.
    term(9'h002, 2'd0); term(9'h003, 2'd0); term(9'h001, 2'd2);
    run_expr("t1", 9'h005, 4'b0000, 5, 2, 1'b0);

    // T2: 1 - 3 = -2.
    term(9'h001, 2'd0); term(9'h003, 2'd1);
    run_expr("t2", 9'h102, 4'b1000, 0, 1, 1'b0);

    // T3: divide by zero keeps 2; final beat is drained.
    term(9'h002, 2'd0); term(9'h000, 2'd3); term(9'h001, 2'd0);
    run_expr("t3", 9'h002, 4'b0010, 0, 3, 1'b0);

    // T4: six +1 terms, limit of five -> 5 with truncation, sixth drained.
    for (int i = 0; i < 6; i++) term(9'h001, 2'd0);
    run_expr("t4", 9'h005, 4'b0001, 0, 1, 1'b0);

    // Exactly MAX_TERMS terms with last on the fifth: no truncation.
    term(9'h001, 2'd0); term(9'h002, 2'd0); term(9'h003, 2'd0);
    term(9'h004, 2'd0); term(9'h005, 2'd0);
    run_expr("five", 9'h00F, 4'b0000, 0, 1, 1'b0);

    // Single negative-zero term: zero flag only, one clock latency.
    term(9'h100, 2'd0);
    run_expr("negzero", 9'h100, 4'b0100, 1, 1, 1'b0);

    // (-3 * 4) / 2 = -6.
    term(9'h103, 2'd0); term(9'h004, 2'd2); term(9'h002, 2'd3);
    run_expr("muldiv", 9'h106, 4'b1000, 0, 1, 1'b0);

    // 200 + 100 wraps in the 8-bit magnitude: 44.
    term(9'h0C8, 2'd0); term(9'h064, 2'd0);
    run_expr("wrap", 9'h02C, 4'b0000, 3, 1, 1'b0);

    // Divide by zero on the last term goes straight to the result.
    term(9'h007, 2'd0); term(9'h100, 2'd3);
    run_expr("dbzlast", 9'h007, 4'b0010, 0, 1, 1'b0);

    // T6: result held 10 clocks with a beat offered throughout and at ack.
    term(9'h004, 2'd0); term(9'h002, 2'd1);
    run_expr("t6", 9'h002, 4'b0000, 0, 10, 1'b1);

    // T5: reset asserted while the first ALU step is executing.
    term(9'h002, 2'd0); term(9'h003, 2'd0); term(9'h001, 2'd2);
    send(q_opnd[0], q_op[0], 1'b0);
    send(q_opnd[1], q_op[1], 1'b0);
    chk("t5_in_exec", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk_reset("t5_async");
    @(posedge clk);
    #1;
    chk_reset("t5_held");
    @(negedge clk);
    rst_n = 1'b1;
    run_expr("t5_after", 9'h005, 4'b0000, 5, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
